// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master and its wait timer.
package apb_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready; flags the cycle that hits TIMEOUT.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic pclk,
   input  logic preset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] count_q, count_d;

   // count_q holds the waited cycles already completed, so the current waiting
   // cycle is number count_q+1 and aborts when that equals TIMEOUT.
   assign expired = enable && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (enable && count_q != 8'hFF)
         count_d = count_q + 8'd1;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: one command in, one APB transfer, one response out.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [7:0]        cmd_wait,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic [7:0]        wait_count,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apb_state_e        state_q;
   logic              psel_q, penable_q, pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q, rdata_q;
   logic [7:0]        wait_q;
   logic              rsp_valid_q, err_q, tmo_q;
   logic              accept, expired;

   assign cmd_ready = (state_q == IDLE);
   assign accept    = cmd_valid && cmd_ready;

   apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .pclk    (pclk),
      .preset  (preset),
      .clear   (accept),
      .enable  ((state_q == ACCESS) && !pready),
      .expired (expired)
   );

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         wait_q      <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (cmd_valid) begin
               pwrite_q <= cmd_write;
               paddr_q  <= cmd_addr;
               pwdata_q <= cmd_wdata;
               wait_q   <= cmd_wait;
               psel_q   <= 1'b1;
               state_q  <= SETUP;
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               // pready wins over a timeout landing on the same edge
               if (pready) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rdata_q     <= pwrite_q ? '0 : prdata;
                  err_q       <= pslverr;
                  tmo_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else if (expired) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rdata_q     <= '0;
                  err_q       <= 1'b1;
                  tmo_q       <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: if (rsp_ready) begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign wait_count  = wait_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = tmo_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max ACCESS cycles waited for pready before abort (legal range 2..255).
REQ-002 SHALL have port: pclk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: preset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both high.
REQ-005 SHALL have ports: cmd_write  input  1  1=write/0=read; cmd_addr  input  8  target address; cmd_wdata  input  8  write data; cmd_wait  input  8  requested slave wait states.
REQ-006 SHALL have ports: rsp_valid  output  1  response present; rsp_ready  input  1  response consumed.
REQ-007 SHALL have ports: rsp_rdata  output  8  read data; rsp_err  output  1  slave error or timeout; rsp_timeout  output  1  abort due to timeout.
REQ-008 SHALL have APB ports: psel, penable, pwrite  output  1 each; paddr, pwdata, wait_count  output  8 each.
REQ-009 SHALL have APB ports: prdata  input  8; pready  input  1; pslverr  input  1.

Function
REQ-010 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; encoding 2 bits, IDLE=0.
REQ-011 SHALL drive cmd_ready=1 only in IDLE; cmd_valid outside IDLE SHALL be ignored, not queued.
REQ-012 SHALL, on cmd_valid&&cmd_ready, register cmd_write/addr/wdata/wait into pwrite/paddr/pwdata/wait_count and enter SETUP next cycle.
REQ-013 SHALL in SETUP drive psel=1, penable=0 for exactly one cycle, then enter ACCESS.
REQ-014 SHALL in ACCESS drive psel=1, penable=1 until pready=1 sampled on a rising edge.
REQ-015 SHALL hold paddr, pwrite, pwdata, wait_count stable from SETUP through the last ACCESS cycle.
REQ-016 SHALL ignore pready, pslverr, prdata outside ACCESS.
REQ-017 SHALL on pready in ACCESS: capture prdata into rsp_rdata (reads; 0 for writes), pslverr into rsp_err, rsp_timeout=0, deassert psel/penable next cycle, enter RESP.
REQ-018 SHALL count ACCESS cycles with pready=0; when count reaches TIMEOUT with pready still 0, deassert psel/penable, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, enter RESP.
REQ-019 SHALL give pready precedence if it rises on the same edge the counter reaches TIMEOUT (normal completion).
REQ-020 SHALL in RESP hold rsp_valid=1 and response fields stable until rsp_ready=1, then return to IDLE.
REQ-021 SHALL reach IDLE in the cycle after handshake, so minimum transfer period is 4 cycles (accept, SETUP, ACCESS, RESP) with zero wait states.
REQ-022 SHALL clear the timeout counter on entry to SETUP; counter width 8 bits, no wrap permitted.

Reset
REQ-023 SHALL on preset=1 immediately force state=IDLE and psel, penable, pwrite, paddr, pwdata, wait_count, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, counter to 0; cmd_ready=1 after release.
REQ-024 SHALL, on reset mid-transfer, drop the transfer silently with no response.

Structure
REQ-025 SHALL take state enum, 8-bit data/address width constants and TIMEOUT default from shared package apb_pkg.
REQ-026 SHALL place the wait/timeout counter in sub-module apb_wait_timer (inputs clear, enable; output expired).

Verification
REQ-027 SHALL cover write 0x22 to 0x11, wait 0, slave pready in first ACCESS -> psel 2 cycles, rsp_valid 1 cycle later, rsp_err=0.
REQ-028 SHALL cover write 0x51 to 0x15, wait 3 -> penable high 4 cycles, paddr/pwdata stable throughout, rsp_err=0.
REQ-029 SHALL cover read 0x15 after prior write, slave returns 0x51 -> rsp_rdata=0x51, rsp_timeout=0.
REQ-030 SHALL cover slave never asserting pready, TIMEOUT=16 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-031 SHALL cover pslverr=1 with pready, and rsp_ready held low 5 cycles -> rsp_err=1, response fields stable, cmd_ready=0 until handshake.
REQ-032 SHALL cover preset asserted mid-ACCESS -> all outputs 0 immediately, no rsp_valid, next command accepted normally.
